// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB2 HS transmit serializer.
package usb_tx_pkg;

  // SYNC goes out LSB-first, so the raw bit stream is 0000_0001.
  localparam logic [7:0] SYNC_BYTE      = 8'h80;
  localparam int         STUFF_LEN      = 6;
  localparam int         EOP_SE0_CYCLES = 2;
  localparam int         ABORT_ONES     = 7;

  localparam logic LINE_J = 1'b1;
  localparam logic LINE_K = 1'b0;

  // Ones counter must be able to hold STUFF_LEN itself (the "stuff due" value).
  localparam int STUFF_CNT_W = $clog2(STUFF_LEN + 1);

  // One down-counter-ish register serves both ABORT and EOP_SE0 timing.
  localparam int AUX_MAX = (ABORT_ONES > EOP_SE0_CYCLES) ? ABORT_ONES : EOP_SE0_CYCLES;
  localparam int AUX_W   = $clog2(AUX_MAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_ABORT,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  // Registered control outputs of the serializer.
  typedef struct packed {
    logic tx_ready;
    logic se0;
    logic oe;
    logic busy;
    logic tx_underrun;
  } tx_ctl_t;

endpackage

// File: rtl/usb_tx_serializer_nrzi_bit_stuffer.sv
// NRZI encoder with bit stuffing. The level register is the line level
// for the cycle after a bit is pushed; stall tells the shifter that the
// next pushed slot will be consumed by a stuffed 0 instead of its raw bit.
module nrzi_bit_stuffer
  import usb_tx_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic bit_valid,
  input  logic bit_raw,
  output logic level,
  output logic stall
);

  logic [STUFF_CNT_W-1:0] ones_q;

  assign stall = (ones_q == STUFF_CNT_W'(STUFF_LEN));

  // Line level and run-length of raw ones; a stuffed 0 or raw 0 toggles.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      level  <= LINE_J;
      ones_q <= '0;
    end else if (bit_valid) begin
      if (stall || !bit_raw) begin
        level  <= ~level;
        ones_q <= '0;
      end else begin
        ones_q <= ones_q + STUFF_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/usb_tx_serializer.sv
// USB2 HS transmit serializer: SYNC, bit stuffing, NRZI, EOP.
// state_q describes what is on the line during the current cycle; the
// output block decodes the next state so every output leaves a flop.
module usb_tx_serializer
  import usb_tx_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       data_out,
  output logic       se0,
  output logic       oe,
  output logic       busy,
  output logic       tx_underrun
);

  tx_state_e        state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;     // remaining raw bits of current byte
  logic [3:0]       bit_cnt_q, bit_cnt_d; // raw bits of current byte already on the line
  logic             last_q, last_d;
  logic [AUX_W-1:0] aux_q, aux_d;         // ABORT / EOP_SE0 cycle count

  logic    push, push_bit, stall, clear;
  logic    ready_d, underrun_d;
  tx_ctl_t ctl_q, ctl_d;

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      last_q    <= 1'b0;
      aux_q     <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      last_q    <= last_d;
      aux_q     <= aux_d;
    end
  end

  // Next-state and bit-slot selection for the coming cycle.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    aux_d      = aux_q;
    push       = 1'b0;
    push_bit   = 1'b0;
    ready_d    = 1'b0;
    underrun_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Byte stays on the bus; it is taken at the SYNC bit-7 handshake.
        if (tx_valid) begin
          state_d   = ST_SYNC;
          push      = 1'b1;
          push_bit  = SYNC_BYTE[0];
          shreg_d   = SYNC_BYTE >> 1;
          bit_cnt_d = 4'd1;
          last_d    = 1'b0;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (bit_cnt_q != 4'd8) begin
          push = 1'b1;
          if (!stall) begin
            push_bit  = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
            // Ready rides with bit 7 so a stuff bit ahead of it delays it too.
            ready_d   = (bit_cnt_q == 4'd7) && !last_q;
          end
        end else if (last_q) begin
          // A stuff bit owed after the final data bit still goes out.
          if (stall) begin
            push = 1'b1;
          end else begin
            state_d = ST_EOP_SE0;
            aux_d   = '0;
          end
        end else if (tx_valid) begin
          // tx_ready is high this cycle: handshake and start the next byte.
          state_d = ST_DATA;
          last_d  = tx_last;
          push    = 1'b1;
          if (stall) begin
            shreg_d   = tx_data;
            bit_cnt_d = 4'd0;
          end else begin
            push_bit  = tx_data[0];
            shreg_d   = tx_data >> 1;
            bit_cnt_d = 4'd1;
          end
        end else begin
          state_d    = ST_ABORT;
          aux_d      = '0;
          underrun_d = 1'b1;
        end
      end
      ST_ABORT: begin
        // Raw ones with no stuffing: simply hold the NRZI level.
        if (aux_q == AUX_W'(ABORT_ONES - 1)) begin
          state_d = ST_EOP_SE0;
          aux_d   = '0;
        end else begin
          aux_d = aux_q + AUX_W'(1);
        end
      end
      ST_EOP_SE0: begin
        if (aux_q == AUX_W'(EOP_SE0_CYCLES - 1)) state_d = ST_EOP_J;
        else                                     aux_d   = aux_q + AUX_W'(1);
      end
      ST_EOP_J: state_d = ST_IDLE;  // forces at least one idle cycle
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state.
  always_comb begin
    ctl_d             = '0;
    ctl_d.oe          = (state_d != ST_IDLE);
    ctl_d.busy        = (state_d != ST_IDLE);
    ctl_d.se0         = (state_d == ST_EOP_SE0);
    ctl_d.tx_ready    = ready_d;
    ctl_d.tx_underrun = underrun_d;
  end

  // Output registers.
  always_ff @(posedge clock) begin
    if (reset) ctl_q <= '0;
    else       ctl_q <= ctl_d;
  end

  assign tx_ready    = ctl_q.tx_ready;
  assign se0         = ctl_q.se0;
  assign oe          = ctl_q.oe;
  assign busy        = ctl_q.busy;
  assign tx_underrun = ctl_q.tx_underrun;

  // EOP and idle drive J and restart the ones count for the next packet.
  assign clear = (state_d == ST_IDLE) || (state_d == ST_EOP_SE0) || (state_d == ST_EOP_J);

  nrzi_bit_stuffer u_stuff (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .bit_valid (push),
    .bit_raw   (push_bit),
    .level     (data_out),
    .stall     (stall)
  );

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed bench for usb_tx_serializer: per-cycle traces compared with
// hand-derived expectation strings ('-' = don't care), cycle 0 being the
// cycle in which tx_valid is first presented.
module tb_usb_tx_serializer;

  logic       clock = 1'b0;
  logic       reset, tx_valid, tx_last;
  logic [7:0] tx_data;
  logic       tx_ready, data_out, se0, oe, busy, tx_underrun;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  usb_tx_serializer dut (
    .clock       (clock),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .data_out    (data_out),
    .se0         (se0),
    .oe          (oe),
    .busy        (busy),
    .tx_underrun (tx_underrun)
  );

  typedef struct {
    string      name;
    int         n;       // bytes offered
    logic [7:0] b0, b1;
    logic       l0, l1;
    bit         hold;    // keep tx_valid/byte asserted across handshakes
    int         ncyc;
    string      line, oe, se0, rdy, unr;
  } vec_t;

  function automatic string rep(input string c, input int n);
    string s = "";
    for (int i = 0; i < n; i++) s = {s, c};
    return s;
  endfunction

  function automatic string b2s(input logic b);
    string s;
    s = (b === 1'b1) ? "1" : "0";
    return s;
  endfunction

  function automatic bit match(input string e, input string a);
    if (e.len() != a.len()) return 1'b0;
    for (int i = 0; i < e.len(); i++)
      if (e.getc(i) != "-" && e.getc(i) != a.getc(i)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string what, input string act, input string exp);
    checks++;
    if (!match(exp, act)) begin
      errors++;
      $display("FAIL %s got %s want %s", what, act, exp);
    end
  endtask

  // Idle outputs: data_out,se0,oe,busy,tx_ready,tx_underrun
  function automatic string idle_snap();
    return {b2s(data_out), b2s(se0), b2s(oe), b2s(busy), b2s(tx_ready), b2s(tx_underrun)};
  endfunction

  // Called just after a posedge with the DUT idle.
  task automatic run_vec(input vec_t v);
    string a_line = "", a_oe = "", a_busy = "", a_se0 = "", a_rdy = "", a_unr = "";
    int    idx = 0;
    logic  hs;
    tx_valid = 1'b1;
    tx_data  = v.b0;
    tx_last  = v.l0;
    for (int k = 0; k < v.ncyc; k++) begin
      @(negedge clock);
      a_line = {a_line, b2s(data_out)};
      a_oe   = {a_oe,   b2s(oe)};
      a_busy = {a_busy, b2s(busy)};
      a_se0  = {a_se0,  b2s(se0)};
      a_rdy  = {a_rdy,  b2s(tx_ready)};
      a_unr  = {a_unr,  b2s(tx_underrun)};
      hs = tx_valid && tx_ready;
      if (k == v.ncyc - 1) tx_valid = 1'b0;
      @(posedge clock); #1;
      if (hs && !v.hold && k != v.ncyc - 1) begin
        idx++;
        if (idx < v.n) begin
          tx_data = v.b1;
          tx_last = v.l1;
        end else begin
          tx_valid = 1'b0;
        end
      end
    end
    check({v.name, " line"},     a_line, v.line);
    check({v.name, " oe"},       a_oe,   v.oe);
    check({v.name, " busy"},     a_busy, v.oe);
    check({v.name, " se0"},      a_se0,  v.se0);
    check({v.name, " tx_ready"}, a_rdy,  v.rdy);
    check({v.name, " underrun"}, a_unr,  v.unr);
    repeat (2) @(posedge clock);
    #1;
  endtask

  vec_t  vecs[7];
  vec_t  t;
  string sy;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    sy = "01010100";  // SYNC on the line starting from J
    vecs[0] = '{name:"one_00", n:1, b0:8'h00, b1:8'h00, l0:1'b1, l1:1'b0, hold:1'b0, ncyc:32,
      line:{"1", sy, "10101010", "--", "1", rep("1", 12)},
      oe:{"0", rep("1", 19), rep("0", 12)},
      se0:{rep("0", 17), "11", rep("0", 13)},
      rdy:{rep("0", 8), "1", rep("0", 23)},
      unr:rep("0", 32)};
    vecs[1] = '{name:"one_ff", n:1, b0:8'hFF, b1:8'h00, l0:1'b1, l1:1'b0, hold:1'b0, ncyc:32,
      line:{"1", sy, "000001111", "--", "1", rep("1", 11)},
      oe:{"0", rep("1", 20), rep("0", 11)},
      se0:{rep("0", 18), "11", rep("0", 12)},
      rdy:{rep("0", 8), "1", rep("0", 23)},
      unr:rep("0", 32)};
    vecs[2] = '{name:"a5_3c", n:2, b0:8'hA5, b1:8'h3C, l0:1'b0, l1:1'b1, hold:1'b0, ncyc:32,
      line:{"1", sy, "01101100", "10000010", "--", "1", rep("1", 4)},
      oe:{"0", rep("1", 27), rep("0", 4)},
      se0:{rep("0", 25), "11", rep("0", 5)},
      rdy:{rep("0", 8), "1", rep("0", 7), "1", rep("0", 15)},
      unr:rep("0", 32)};
    vecs[3] = '{name:"underrun", n:1, b0:8'hA5, b1:8'h00, l0:1'b0, l1:1'b0, hold:1'b0, ncyc:32,
      line:{"1", sy, "01101100", rep("0", 7), "--", "1", rep("1", 5)},
      oe:{"0", rep("1", 26), rep("0", 5)},
      se0:{rep("0", 24), "11", rep("0", 6)},
      rdy:{rep("0", 8), "1", rep("0", 7), "1", rep("0", 15)},
      unr:{rep("0", 17), "1", rep("0", 14)}};
    vecs[4] = '{name:"ff_00_shift", n:2, b0:8'hFF, b1:8'h00, l0:1'b0, l1:1'b1, hold:1'b0, ncyc:32,
      line:{"1", sy, "000001111", "01010101", "--", "1", rep("1", 3)},
      oe:{"0", rep("1", 28), rep("0", 3)},
      se0:{rep("0", 26), "11", rep("0", 4)},
      rdy:{rep("0", 8), "1", rep("0", 8), "1", rep("0", 14)},
      unr:rep("0", 32)};
    vecs[5] = '{name:"00_fc_tailstuff", n:2, b0:8'h00, b1:8'hFC, l0:1'b0, l1:1'b1, hold:1'b0, ncyc:32,
      line:{"1", sy, "10101010", "10000000", "1", "--", "1", rep("1", 3)},
      oe:{"0", rep("1", 28), rep("0", 3)},
      se0:{rep("0", 26), "11", rep("0", 4)},
      rdy:{rep("0", 8), "1", rep("0", 7), "1", rep("0", 15)},
      unr:rep("0", 32)};
    vecs[6] = '{name:"back_to_back", n:1, b0:8'h00, b1:8'h00, l0:1'b1, l1:1'b1, hold:1'b1, ncyc:41,
      line:{"1", sy, "10101010", "--", "1", "1", sy, "10101010", "--", "1", "1"},
      oe:{"0", rep("1", 19), "0", rep("1", 19), "0"},
      se0:{rep("0", 17), "11", rep("0", 18), "11", rep("0", 2)},
      rdy:{rep("0", 8), "1", rep("0", 19), "1", rep("0", 12)},
      unr:rep("0", 41)};

    // Reset state
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", idle_snap(), "100000");
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of DATA, then a clean repeat of the 0x00 packet
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    tx_last  = 1'b1;
    repeat (12) @(posedge clock);
    #1;
    check("pre_reset_active", {b2s(oe), b2s(busy)}, "11");
    tx_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock);
    #1;
    check("reset_mid_data", idle_snap(), "100000");
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("post_reset_idle", idle_snap(), "100000");
    t      = vecs[0];
    t.name = "after_reset";
    run_vec(t);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_tx_serializer.md
Name: usb_tx_serializer

Overview:
Transmit-side counterpart of the USB2 HS data-recovery path. Accepts packet bytes over a valid/ready handshake and drives one line bit per clock (480 MHz bit clock). Prepends SYNC, bit-stuffs, NRZI-encodes, and appends EOP. Sits between the link-layer packet builder and the HS line driver.

Parameters:
SYNC_BYTE, 8'h80, SYNC pattern, sent LSB-first (raw bits 0000_0001).
STUFF_LEN, 6, consecutive raw 1s after which a 0 is inserted.
EOP_SE0_CYCLES, 2, SE0 cycles in EOP before the final J.
ABORT_ONES, 7, unstuffed raw 1s sent on underrun abort.

Ports:
clock  input  1  bit clock, one line bit per cycle
reset  input  1  synchronous, active-high
tx_valid  input  1  tx_data/tx_last valid
tx_data  input  8  packet byte, serialized LSB-first
tx_last  input  1  byte is final byte of packet
tx_ready  output  1  one-cycle pulse; byte transferred when tx_valid && tx_ready
data_out  output  1  NRZI line level, 1 = J, 0 = K
se0  output  1  drive SE0 (overrides data_out)
oe  output  1  line driver enable
busy  output  1  high from packet start to end of EOP J cycle
tx_underrun  output  1  one-cycle pulse when abort begins

Behaviour:
- Reset values: data_out=1, se0=0, oe=0, busy=0, tx_ready=0, tx_underrun=0; stuff counter=0, NRZI level=J. Reset mid-packet returns all outputs to these values on the next edge, with no EOP.
- All outputs are registered.
- FSM states: IDLE, SYNC, DATA, ABORT, EOP_SE0, EOP_J.
- IDLE: when tx_valid=1 is sampled at cycle 0, move to SYNC. oe=1 and busy=1 from cycle 1. SYNC bit 0 is on the line at cycle 1. The byte is not consumed in IDLE.
- tx_ready pulses during the cycle the last raw bit (bit 7) of SYNC or of the current data byte is driven:
  - tx_valid=1: load tx_data/tx_last and go to (or stay in) DATA.
  - tx_valid=0 and the current byte is not last (SYNC is never last): underrun. Pulse tx_underrun, go to ABORT.
  - Current byte is last: tx_ready is not asserted; go to EOP_SE0 after any pending stuff bit.
- Bit stuffing:
  - Counter of consecutive raw 1s spans SYNC and all byte boundaries.
  - When the count reaches STUFF_LEN, the next line bit is a stuffed 0. The shifter holds, the counter clears, and tx_ready timing shifts by that one cycle.
  - A stuff bit due after the final data bit is sent before EOP.
- NRZI: raw 0 toggles the level, raw 1 holds it.
- ABORT: ABORT_ONES raw 1s, no stuffing (line constant), then EOP_SE0.
- EOP_SE0: se0=1 for EOP_SE0_CYCLES cycles, with oe=1.
- EOP_J: data_out=1, se0=0, oe=1 for one cycle. Next cycle: oe=0, busy=0, IDLE; NRZI level and stuff counter reinitialised.
- Minimum one IDLE cycle between packets, even if tx_valid is held high.

Decomposition:
- Package usb_tx_pkg: FSM state enum, SYNC_BYTE, STUFF_LEN, line-level constants (LINE_J=1, LINE_K=0).
- One sub-module, nrzi_bit_stuffer. Input: raw bit with valid, plus clear. Outputs: NRZI level and a stall flag telling the shifter to hold for one cycle.

Test Plan:
1. One byte 0x00, tx_last=1 -> data_out over 16 cycles: 0,1,0,1,0,1,0,0 then 1,0,1,0,1,0,1,0. Then se0=1 for 2 cycles, then J with oe=1. oe high for exactly 19 cycles; tx_ready pulses once (cycle 8, SYNC bit 7).
2. One byte 0xFF, tx_last=1 -> after SYNC: 0,0,0,0,0 (5 ones), stuffed 1, then 1,1,1. 9 data cycles, oe high 20 cycles.
3. Bytes 0xA5, 0x3C (last on 0x3C), tx_valid held -> tx_ready pulses exactly twice, at SYNC bit 7 and byte0 bit 7 (8 cycles apart). No stuff bits; EOP follows 0x3C bit 7.
4. Underrun: first byte 0xA5 not last, tx_valid=0 at next tx_ready -> tx_underrun pulse, data_out constant for 7 cycles, then 2 SE0 + J, busy drops.
5. Reset asserted during DATA -> next cycle oe=0, data_out=1, se0=0, busy=0. A following 0x00 packet reproduces scenario 1 exactly.
6. Two single-byte packets with tx_valid held continuously -> ≥1 cycle with oe=0 between the first EOP J and the second SYNC bit 0. The second SYNC starts from level J.
